lc3b_dcache: RTL and testbench
==============================

Name: lc3b_dcache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM stage and physical memory.
- Geometry comes from the package types: 8 sets (lc3b_set), 9-bit tag (lc3b_tag), 16-byte line (lc3b_burst, lc3b_cache_offset).
- Serves 16-bit word and byte accesses from the pipeline.
- Fills and evicts whole 128-bit lines over a single-beat physical-memory handshake.

Parameters:
- None. Geometry is fixed by package types: address = {tag[15:7], set[6:4], offset[3:0]}.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_address  in  16  CPU byte address; bit 0 ignored, bits [3:1] select the word in the line
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- mem_wmask  in  2  byte enables; bit0 = low byte, bit1 = high byte
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  selected word of the addressed line
- mem_resp  out  1  access complete this cycle
- pmem_address  out  16  line address, low 4 bits always 0
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  128  victim line data
- pmem_rdata  in  128  fill line data
- pmem_resp  in  1  physical access complete; valid for one cycle

Behaviour:
- Arrays (per set): valid[8], dirty[8], tag[8] x 9 bits, data[8] x 128 bits.
  - Reset clears all valid and dirty bits.
  - Tag and data arrays are not reset.
- Request rules:
  - The CPU holds address, controls and data stable from request assertion until the cycle mem_resp=1.
  - mem_read and mem_write both high is treated as a write.
- hit = valid[set] && tag[set]==mem_address[15:7].
- FSM states: IDLE, WRITEBACK, FILL. Reset state is IDLE.
- IDLE:
  - Read hit: mem_resp=1 in the same cycle (combinational). mem_rdata = data[set][16*offset[3:1] +: 16].
  - Write hit: mem_resp=1 in the same cycle. At the clock edge, the masked bytes are merged into the line and dirty[set]=1.
  - wmask=2'b00 on a write hit: mem_resp=1, data unchanged, dirty still set.
  - Miss with !(valid&&dirty): go to FILL.
  - Miss with valid&&dirty: go to WRITEBACK.
  - No request: stay in IDLE, mem_resp=0.
- WRITEBACK:
  - pmem_write=1.
  - pmem_address={tag[set], set, 4'b0}.
  - pmem_wdata=data[set].
  - Hold these until pmem_resp, then go to FILL and clear dirty[set].
- FILL:
  - pmem_read=1, pmem_address={mem_address[15:4], 4'b0}.
  - On pmem_resp: data[set]=pmem_rdata, tag[set]=mem_address[15:7], valid=1, dirty=0; go to IDLE.
  - The access then completes as a hit on the following cycle.
- Latency:
  - Hit: 0 extra cycles (resp in the request cycle).
  - Clean miss: fill latency + 1 cycle.
  - Dirty miss: writeback + fill + 1 cycle.
- mem_resp is 0 in WRITEBACK and FILL.
- pmem_read and pmem_write are never both 1. Both are 0 in IDLE.
- pmem_resp seen in IDLE is ignored.
- pmem_wdata and pmem_address are don't-care when the corresponding request is low.
- While rst=1: mem_resp=0, pmem_read=0, pmem_write=0.
- Reset mid-operation: next state is IDLE and all valid bits are cleared. Any in-progress fill or writeback is abandoned; the line is not written.
- Set conflict: an access to the same set with a different tag evicts the line (direct-mapped, no replacement choice).

Test Plan:
1. After reset, read 0x1232 with memory returning line L (word1=0xBEEF):
   - pmem_read rises next edge with pmem_address=0x1230.
   - After pmem_resp, mem_resp=1 one cycle later with mem_rdata=0xBEEF.
   - A repeat read of 0x1232 gets resp in the same cycle with no pmem activity.
2. Write hit to 0x1234, wmask=2'b01, wdata=0xAA55 on a line whose word2=0x1122:
   - mem_resp=1 in the same cycle.
   - A subsequent read of 0x1234 returns 0x1155.
   - dirty[3]=1.
3. With the dirty line tag 0x024 in set 3, read 0x5630 (set 3, tag 0x0AC):
   - pmem_write with pmem_address=0x1230 and pmem_wdata equal to the modified line.
   - Then pmem_read with 0x5630.
   - mem_resp only after the fill completes. pmem_read and pmem_write never overlap.
4. Simultaneous mem_read=mem_write=1, wmask=2'b11, wdata=0x0F0F on a hit: treated as a write; a later read returns 0x0F0F.
5. Assert rst for one cycle during FILL (before pmem_resp):
   - pmem_read drops next cycle and state is IDLE.
   - A re-read of the previously valid address misses and issues pmem_read.
6. Wrap/offset check: read byte addresses 0x00E and 0x00F on the same line; both return word7 of the line.

Source files
------------

// File: rtl/lc3b_dcache.sv
// lc3b_dcache: direct-mapped, write-back, write-allocate data cache.
// 8 sets x 16-byte lines; 9-bit tag; single-beat 128-bit pmem port.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_address/read/write/wmask/wdata  CPU request (held until mem_resp)
//   mem_rdata/mem_resp  CPU read data and completion strobe
//   pmem_address/read/write/wdata      line fill / writeback request
//   pmem_rdata/pmem_resp               line data and completion strobe
module lc3b_dcache (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_wmask,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef logic [2:0]   lc3b_set;
    typedef logic [8:0]   lc3b_tag;
    typedef logic [127:0] lc3b_burst;
    typedef logic [2:0]   lc3b_word_sel;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL
    } state_t;

    state_t    state_q, state_d;
    logic [7:0] valid_q, valid_d;
    logic [7:0] dirty_q, dirty_d;
    lc3b_tag   tag_q  [8];
    lc3b_burst data_q [8];

    lc3b_set      set;
    lc3b_tag      tag;
    lc3b_word_sel word_sel;
    lc3b_burst    line;
    lc3b_burst    merged;
    lc3b_burst    data_wline;
    logic         data_we;
    logic         tag_we;
    logic         hit;
    logic         is_req;
    logic         unused_addr0;

    assign set          = mem_address[6:4];
    assign tag          = mem_address[15:7];
    assign word_sel     = mem_address[3:1];
    assign unused_addr0 = mem_address[0];

    assign line   = data_q[set];
    assign hit    = valid_q[set] && (tag_q[set] == tag);
    assign is_req = mem_read | mem_write;

    assign mem_rdata = line[{word_sel, 4'h0} +: 16];

    // Byte-merge of the write data into the currently resident line.
    always_comb begin
        merged = line;
        if (mem_wmask[0]) begin
            merged[{word_sel, 4'h0} +: 8] = mem_wdata[7:0];
        end
        if (mem_wmask[1]) begin
            merged[{word_sel, 4'h8} +: 8] = mem_wdata[15:8];
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {mem_address[15:4], 4'h0};
        pmem_wdata   = line;
        data_we      = 1'b0;
        data_wline   = merged;
        tag_we       = 1'b0;

        // Outputs and array writes are suppressed while reset is held so
        // an abandoned fill never lands in the data array.
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_req) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            if (mem_write) begin
                                data_we      = 1'b1;
                                data_wline   = merged;
                                dirty_d[set] = 1'b1;
                            end
                        end else if (valid_q[set] && dirty_q[set]) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {tag_q[set], set, 4'h0};
                    if (pmem_resp) begin
                        dirty_d[set] = 1'b0;
                        state_d      = S_FILL;
                    end
                end
                S_FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        data_we      = 1'b1;
                        data_wline   = pmem_rdata;
                        tag_we       = 1'b1;
                        valid_d[set] = 1'b1;
                        dirty_d[set] = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[set] <= data_wline;
        end
        if (tag_we) begin
            tag_q[set] <= tag;
        end
    end

endmodule

// File: tb/tb_lc3b_dcache.sv
// tb_lc3b_dcache: directed + random accesses against a transparent-memory
// reference model with a per-set residency model for pmem traffic.
module tb_lc3b_dcache;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_wmask;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    lc3b_dcache dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    // phys: backing store; arch: what the CPU should observe.
    logic [127:0] phys [4096];
    logic [127:0] arch [4096];
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [8:0]   m_tag   [8];

    int total = 0;
    int bad   = 0;

    int           r_resp_k, r_rd_first, r_wr_first, r_wb_resp, r_fill_resp;
    int           r_overlap;
    logic [15:0]  r_rdata, r_wb_addr, r_fill_addr;
    logic [127:0] r_wb_data;

    task automatic chk(input string tg, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    task automatic chk_int(input string tg, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tg, obs, exp);
        end
    endtask

    function automatic logic [15:0] arch_word(input logic [15:0] a);
        logic [127:0] l;
        l = arch[a[15:4]];
        return l[a[3:1]*16 +: 16];
    endfunction

    // Drive one CPU request and act as physical memory until mem_resp.
    task automatic run_access(input logic [15:0] a, input bit rd, input bit wr,
                              input logic [1:0] wm, input logic [15:0] wd,
                              input int dly);
        int  wcnt;
        bit  done;
        r_resp_k = -1; r_rd_first = -1; r_wr_first = -1;
        r_wb_resp = -1; r_fill_resp = -1; r_overlap = 0;
        r_rdata = '0; r_wb_addr = '0; r_fill_addr = '0; r_wb_data = '0;
        wcnt = 0;
        done = 1'b0;
        @(negedge clk);
        mem_address = a;
        mem_read    = rd;
        mem_write   = wr;
        mem_wmask   = wm;
        mem_wdata   = wd;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (pmem_read && pmem_write) r_overlap = 1;
            if (mem_resp) begin
                r_resp_k = k;
                r_rdata  = mem_rdata;
                done     = 1'b1;
            end else if (pmem_write) begin
                if (r_wr_first < 0) begin
                    r_wr_first = k;
                    r_wb_addr  = pmem_address;
                    r_wb_data  = pmem_wdata;
                end
                if (wcnt == dly) begin
                    phys[pmem_address[15:4]] = pmem_wdata;
                    pmem_resp = 1'b1;
                    r_wb_resp = k;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else if (pmem_read) begin
                if (r_rd_first < 0) begin
                    r_rd_first  = k;
                    r_fill_addr = pmem_address;
                end
                if (wcnt == dly) begin
                    pmem_rdata  = phys[pmem_address[15:4]];
                    pmem_resp   = 1'b1;
                    r_fill_resp = k;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_op(input logic [15:0] a, input bit rd, input bit wr,
                         input logic [1:0] wm, input logic [15:0] wd,
                         input int dly);
        logic [2:0]  s;
        logic [8:0]  tg;
        logic [11:0] victim;
        logic [15:0] exp_rd;
        bit          hit, evict;
        s      = a[6:4];
        tg     = a[15:7];
        hit    = m_valid[s] && (m_tag[s] == tg);
        evict  = !hit && m_valid[s] && m_dirty[s];
        victim = {m_tag[s], s};
        exp_rd = arch_word(a);
        run_access(a, rd, wr, wm, wd, dly);
        chk_int("resp_seen", int'(r_resp_k >= 0), 1);
        chk_int("no_overlap", r_overlap, 0);
        if (hit) begin
            chk_int("hit_lat", r_resp_k, 0);
            chk_int("hit_no_rd", r_rd_first, -1);
            chk_int("hit_no_wr", r_wr_first, -1);
        end else begin
            if (evict) begin
                chk_int("wb_start", r_wr_first, 1);
                chk("wb_addr", r_wb_addr, {victim, 4'h0});
                chk("wb_data", r_wb_data, arch[victim]);
                chk_int("fill_after_wb", r_rd_first, r_wb_resp + 1);
            end else begin
                chk_int("clean_no_wb", r_wr_first, -1);
                chk_int("fill_start", r_rd_first, 1);
            end
            chk("fill_addr", r_fill_addr, {a[15:4], 4'h0});
            chk_int("miss_lat", r_resp_k, r_fill_resp + 1);
            m_valid[s] = 1'b1;
            m_tag[s]   = tg;
            m_dirty[s] = 1'b0;
        end
        if (wr) begin
            m_dirty[s] = 1'b1;
            if (wm[0]) arch[a[15:4]][a[3:1]*16 +: 8] = wd[7:0];
            if (wm[1]) arch[a[15:4]][a[3:1]*16 + 8 +: 8] = wd[15:8];
        end else begin
            chk("rdata", r_rdata, exp_rd);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < 4096; i++) arch[i] = phys[i];
    endtask

    logic [8:0] tpool [4];

    initial begin
        rst         = 1'b1;
        mem_address = 16'h0;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        mem_wmask   = 2'b00;
        mem_wdata   = 16'h0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            phys[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        phys[12'h123][31:16] = 16'hBEEF;
        phys[12'h123][47:32] = 16'h1122;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_resp", 128'(mem_resp), 128'(0));
        chk("rst_pmem_rd", 128'(pmem_read), 128'(0));
        chk("rst_pmem_wr", 128'(pmem_write), 128'(0));
        @(negedge clk);
        rst      = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_resp", 128'(mem_resp), 128'(0));
        chk("idle_pmem_rd", 128'(pmem_read), 128'(0));

        // Clean miss then hit.
        do_op(16'h1232, 1, 0, 2'b00, 16'h0, 2);
        chk("t1_fill_addr", r_fill_addr, 16'h1230);
        chk("t1_rdata", r_rdata, 16'hBEEF);
        do_op(16'h1232, 1, 0, 2'b00, 16'h0, 0);
        chk("t1_hit_rdata", r_rdata, 16'hBEEF);

        // Low-byte write hit.
        do_op(16'h1234, 0, 1, 2'b01, 16'hAA55, 0);
        chk_int("t2_wr_lat", r_resp_k, 0);
        do_op(16'h1234, 1, 0, 2'b00, 16'h0, 0);
        chk("t2_rdata", r_rdata, 16'h1155);

        // Dirty eviction by a conflicting tag in set 3.
        do_op(16'h5630, 1, 0, 2'b00, 16'h0, 1);
        chk("t3_wb_addr", r_wb_addr, 16'h1230);
        chk("t3_fill_addr", r_fill_addr, 16'h5630);
        chk("t3_phys", phys[12'h123][47:32], 16'h1155);

        // Read and write together behave as a write.
        do_op(16'h5632, 1, 1, 2'b11, 16'h0F0F, 0);
        do_op(16'h5632, 1, 0, 2'b00, 16'h0, 0);
        chk("t4_rdata", r_rdata, 16'h0F0F);

        // Reset in the middle of a fill.
        @(negedge clk);
        mem_address = 16'h2A40;
        mem_read    = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_fill_active", 128'(pmem_read), 128'(1));
        rst = 1'b1;
        #1;
        chk("t5_rst_resp", 128'(mem_resp), 128'(0));
        chk("t5_rst_pmem_rd", 128'(pmem_read), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_after_rst_rd", 128'(pmem_read), 128'(0));
        mem_read = 1'b0;
        model_reset();
        do_op(16'h5632, 1, 0, 2'b00, 16'h0, 1);
        chk_int("t5_remiss", r_rd_first, 1);

        // Odd byte address selects the same word.
        do_op(16'h000E, 1, 0, 2'b00, 16'h0, 0);
        chk("t6_e", r_rdata, arch[0][127:112]);
        do_op(16'h000F, 1, 0, 2'b00, 16'h0, 0);
        chk("t6_f", r_rdata, arch[0][127:112]);

        // Random traffic over a small tag pool to force conflicts.
        for (int i = 0; i < 4; i++) tpool[i] = 9'($urandom);
        for (int n = 0; n < 250; n++) begin
            logic [15:0] a;
            int          op;
            a  = {tpool[$urandom_range(3)], 3'($urandom), 4'($urandom)};
            op = $urandom_range(3);
            do_op(a, op != 2, op >= 2, 2'($urandom), 16'($urandom),
                  $urandom_range(3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
